// File: rtl/biriscv_div_unit.sv
// biriscv_div_unit: out-of-pipe iterative RV32M divider.
// One restoring radix-2 step per cycle: 32 RUN cycles, then a single DONE
// cycle that pulses complete_o with the sign-corrected quotient or remainder.
module biriscv_div_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [31:0] opcode_i,
    input  logic [31:0] operand_ra_i,
    input  logic [31:0] operand_rb_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        complete_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] quot_q;       // dividend bits shifting out, quotient bits shifting in
    logic [31:0] rem_q;        // partial remainder (always < divisor, fits in 32 bits)
    logic [31:0] divisor_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        is_rem_q;
    logic [5:0]  count_q;
    logic [31:0] result_q;
    logic        complete_q;

    // Two's-complement negate when the captured sign flag is set.
    function automatic logic [31:0] apply_sign(input logic [31:0] value, input logic neg);
        return neg ? (~value + 32'd1) : value;
    endfunction

    // Magnitude of a value that is to be treated as signed.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic neg);
        return neg ? (~value + 32'd1) : value;
    endfunction

    // ---------------------------------------------------------------
    // Operation decode (only used on the start edge)
    // ---------------------------------------------------------------
    logic [2:0]  funct3;
    logic        op_is_div_s;
    logic        op_is_rem_s;
    logic        op_is_rem;
    logic        ra_neg;
    logic        rb_neg;
    logic [31:0] ra_mag;
    logic [31:0] rb_mag;
    logic        q_neg_d;
    logic        r_neg_d;

    assign funct3      = opcode_i[14:12];
    assign op_is_div_s = (funct3 == 3'b100);
    assign op_is_rem_s = (funct3 == 3'b110);
    // 110/111 are remainders; every other code behaves as DIVU or DIV.
    assign op_is_rem   = funct3[2] & funct3[1];
    assign ra_neg      = (op_is_div_s | op_is_rem_s) & operand_ra_i[31];
    assign rb_neg      = (op_is_div_s | op_is_rem_s) & operand_rb_i[31];
    assign ra_mag      = magnitude(operand_ra_i, ra_neg);
    assign rb_mag      = magnitude(operand_rb_i, rb_neg);
    // A zero divisor yields an all-ones quotient that must not be negated.
    assign q_neg_d     = op_is_div_s & (ra_neg ^ rb_neg) & (operand_rb_i != 32'd0);
    assign r_neg_d     = op_is_rem_s & ra_neg;

    // ---------------------------------------------------------------
    // One restoring division step
    // ---------------------------------------------------------------
    logic [32:0] shifted;      // 33-bit partial remainder after the left shift
    logic [33:0] trial;
    logic        trial_ok;
    logic [31:0] rem_step;
    logic [31:0] quot_step;

    assign shifted   = {rem_q, quot_q[31]};
    assign trial     = {1'b0, shifted} - {2'b00, divisor_q};
    assign trial_ok  = ~trial[33];
    assign rem_step  = trial_ok ? trial[31:0] : shifted[31:0];
    assign quot_step = {quot_q[30:0], trial_ok};

    // Bits intentionally not consumed: opcode fields outside funct3, and the
    // top trial bit, which is always zero once the subtraction succeeds.
    logic unused_bits;
    assign unused_bits = ^{opcode_i[31:15], opcode_i[11:0], trial[32]};

    // Control FSM and datapath; reset clears everything, flush aborts.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            quot_q     <= 32'd0;
            rem_q      <= 32'd0;
            divisor_q  <= 32'd0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            is_rem_q   <= 1'b0;
            count_q    <= 6'd0;
            result_q   <= 32'd0;
            complete_q <= 1'b0;
        end else if (flush_i) begin
            state_q    <= ST_IDLE;
            complete_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    complete_q <= 1'b0;
                    if (valid_i) begin
                        state_q   <= ST_RUN;
                        quot_q    <= ra_mag;
                        rem_q     <= 32'd0;
                        divisor_q <= rb_mag;
                        q_neg_q   <= q_neg_d;
                        r_neg_q   <= r_neg_d;
                        is_rem_q  <= op_is_rem;
                        count_q   <= 6'd0;
                    end
                end
                ST_RUN: begin
                    quot_q  <= quot_step;
                    rem_q   <= rem_step;
                    count_q <= count_q + 6'd1;
                    if (count_q == 6'd31) begin
                        state_q    <= ST_DONE;
                        complete_q <= 1'b1;
                        result_q   <= is_rem_q ? apply_sign(rem_step, r_neg_q)
                                               : apply_sign(quot_step, q_neg_q);
                    end
                end
                ST_DONE: begin
                    // valid_i is still high here during the stall; do not restart.
                    state_q    <= ST_IDLE;
                    complete_q <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    complete_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = (state_q == ST_RUN);
    assign complete_o = complete_q;
    assign result_o   = result_q;

endmodule

// File: tb/tb_biriscv_div_unit.sv
// Self-checking bench for biriscv_div_unit: directed corner cases, flush and
// reset aborts, then a random sweep against an RV32M reference model.
module tb_biriscv_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] opcode;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        flush;
  logic        busy;
  logic        complete;
  logic [31:0] result;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result;

  always #5 clk = ~clk;

  biriscv_div_unit dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .valid_i      (valid),
    .opcode_i     (opcode),
    .operand_ra_i (ra),
    .operand_rb_i (rb),
    .flush_i      (flush),
    .busy_o       (busy),
    .complete_o   (complete),
    .result_o     (result)
  );

  // RV32M reference behaviour.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (f3)
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      3'b111: return (b == 32'd0) ? a : (a % b);
      default: return (b == 32'd0) ? 32'hFFFF_FFFF : (a / b);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    valid  = 1'b1;
    opcode = {17'h0, f3, 5'd0, 7'h33};
    ra     = a;
    rb     = b;
  endtask

  // Full operation: start, wait for the completion pulse, score the result.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input bit hold);
    int          n;
    int          busy_cnt;
    bit          seen;
    logic [31:0] e;
    @(negedge clk);
    drive_start(f3, a, b);
    exp_q.push_back(ref_model(f3, a, b));
    @(posedge clk);
    n = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (!hold) valid = 1'b0;
      if (busy) busy_cnt++;
      if (complete) seen = 1'b1;
    end
    e = exp_q.pop_front();
    if (seen) begin
      chk({tag, "_result"}, result, e);
      chk({tag, "_latency"}, n, 33);
      chk({tag, "_busy_cycles"}, busy_cnt, 32);
      last_result = result;
    end else begin
      chk({tag, "_timeout"}, {31'd0, complete}, 32'd1);
    end
    // valid may still be high through DONE; the unit must be idle, not restarted.
    @(negedge clk);
    chk({tag, "_after"}, {30'd0, busy, complete}, 32'd0);
    valid = 1'b0;
  endtask

  // Start an operation and abort it with flush or reset at RUN cycle 'at'.
  task automatic abort_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int at, input bit use_rst);
    bit seen;
    @(negedge clk);
    drive_start(f3, a, b);
    @(posedge clk);
    for (int n = 1; n <= at; n++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    if (use_rst) rst_n = 1'b0;
    else         flush = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b0;
    if (use_rst) last_result = 32'd0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_complete"}, {31'd0, complete}, 32'd0);
    chk({tag, "_result"}, result, last_result);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (complete) seen = 1'b1;
    end
    chk({tag, "_no_complete"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    bit          seen;

    rst_n = 1'b0; valid = 1'b0; flush = 1'b0;
    opcode = 32'd0; ra = 32'd0; rb = 32'd0;
    last_result = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_complete", {31'd0, complete}, 32'd0);
    chk("reset_result", result, 32'd0);

    // Directed cases.
    do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 1'b1);
    chk("divu_100_7_value", last_result, 32'h0000_000E);
    do_op("rem_m100_7", 3'b110, 32'hFFFF_FF9C, 32'd7, 1'b1);
    chk("rem_m100_7_value", last_result, 32'hFFFF_FFFE);
    do_op("div_m100_7", 3'b100, 32'hFFFF_FF9C, 32'd7, 1'b0);
    chk("div_m100_7_value", last_result, 32'hFFFF_FFF2);
    do_op("div_neg_by0", 3'b100, 32'hFFFF_FFF6, 32'd0, 1'b1);
    chk("div_neg_by0_value", last_result, 32'hFFFF_FFFF);
    do_op("divu_5_by0", 3'b101, 32'd5, 32'd0, 1'b0);
    do_op("rem_neg_by0", 3'b110, 32'hFFFF_FFF6, 32'd0, 1'b1);
    chk("rem_neg_by0_value", last_result, 32'hFFFF_FFF6);
    do_op("remu_5_by0", 3'b111, 32'd5, 32'd0, 1'b0);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("div_ovf_value", last_result, 32'h8000_0000);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op("div_pos_neg", 3'b100, 32'd7, 32'hFFFF_FFFE, 1'b0);

    // Flush at RUN cycle 10, then a fresh divide.
    abort_op("flush_run10", 3'b101, 32'd1000, 32'd3, 10, 1'b0);
    do_op("divu_9_3", 3'b101, 32'd9, 32'd3, 1'b1);
    chk("divu_9_3_value", last_result, 32'd3);

    // Reset at RUN cycle 20.
    abort_op("reset_run20", 3'b100, 32'd12345, 32'd17, 20, 1'b1);

    // flush together with valid in IDLE: no start.
    @(negedge clk);
    drive_start(3'b101, 32'd50, 32'd5);
    flush = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    flush = 1'b0;
    chk("flush_wins_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    repeat (36) begin
      @(negedge clk);
      if (complete) seen = 1'b1;
    end
    chk("flush_wins_no_complete", {31'd0, seen}, 32'd0);
    chk("flush_wins_result", result, last_result);

    // Random sweep with occasional aborts.
    for (int i = 0; i < 300; i++) begin
      f3 = 3'($urandom_range(4, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 16));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0)
        abort_op("rand_abort", f3, a, b, $urandom_range(1, 32), 1'($urandom_range(0, 1)));
      else
        do_op("rand_op", f3, a, b, 1'($urandom_range(0, 1)));
    end

    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
